// File: rtl/multiplex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiplex_pkg
//  Description : Shared types and default framing words for the transmit
//                framer and the receive-side frame detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package multiplex_pkg;

    // Framer states. Values are fixed so that state dumps read the same
    // in every tool.
    typedef enum logic [2:0] {
        TRAIN = 3'd0,
        IDLE  = 3'd1,
        SOF   = 3'd2,
        DATA  = 3'd3,
        EOF   = 3'd4
    } state_t;

    // Default line words.
    localparam logic [7:0] c_train_word = 8'hF0;
    localparam logic [7:0] c_idle_word  = 8'h00;
    localparam logic [7:0] c_sof_word   = 8'hBC;
    localparam logic [7:0] c_eof_word   = 8'hFD;

    // True while a frame is in flight (SOF through EOF). A training
    // request seen here must be deferred until the frame has closed.
    function automatic logic is_frame_state(input state_t s);
        return (s == SOF) || (s == DATA) || (s == EOF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/skew_shift.sv
`default_nettype none
// ============================================================================
//  Module      : skew_shift
//  Description : Transmit bit-skew stage. Keeps the current and previous
//                framer words and selects an 8-bit window out of their
//                concatenation, registered.
//                  par_clock - word clock
//                  reset     - asynchronous, active-high
//                  fsm_word  - word produced by the framer this cycle
//                  shift     - skew 0..7; top 'shift' bits of the output
//                              come from the older word
//                  data_out  - registered word to the serializer
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_shift (
    input  logic       par_clock,
    input  logic       reset,
    input  logic [7:0] fsm_word,
    input  logic [2:0] shift,
    output logic [7:0] data_out
);

    logic [7:0]  r_word_q;
    // Only the low seven bits of the previous word can ever land in the
    // window (shift tops out at 7), so bit 7 is not stored.
    logic [6:0]  r_prev_q;
    logic [7:0]  r_data_out;
    logic [14:0] w_ext;

    assign w_ext = {r_prev_q, r_word_q};

    always_ff @(posedge par_clock or posedge reset) begin
        if (reset) begin
            r_word_q   <= 8'h00;
            r_prev_q   <= 7'h00;
            r_data_out <= 8'h00;
        end else begin
            r_word_q   <= fsm_word;
            r_prev_q   <= r_word_q[6:0];
            r_data_out <= w_ext[shift +: 8];
        end
    end

    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: rtl/multiplex_framer.sv
`default_nettype none
// ============================================================================
//  Module      : multiplex_framer
//  Description : Transmit framer for an external 8:1 serializer. Emits a
//                training burst, then SOF / payload / EOF frames with IDLE
//                fill, through a programmable 0-7 bit skew stage.
//                  par_clock   - word clock, one word per cycle
//                  reset       - asynchronous, active-high
//                  train_req   - level request for a training burst
//                  data_in     - payload byte
//                  data_valid  - data_in valid
//                  data_last   - data_in is the final byte of the frame
//                  data_ready  - framer consumes data_in this cycle
//                  shift       - transmit bit skew 0..7
//                  data_out    - word to serializer (2-cycle latency)
//                  training    - framer is generating TRAIN words
//                  frame_count - completed frames, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplex_framer
    import multiplex_pkg::*;
#(
    parameter logic [7:0]  TRAIN_WORD = c_train_word,
    parameter int unsigned TRAIN_LEN  = 64,
    parameter logic [7:0]  IDLE_WORD  = c_idle_word,
    parameter logic [7:0]  SOF_WORD   = c_sof_word,
    parameter logic [7:0]  EOF_WORD   = c_eof_word
) (
    input  logic        par_clock,
    input  logic        reset,
    input  logic        train_req,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        data_last,
    output logic        data_ready,
    input  logic [2:0]  shift,
    output logic [7:0]  data_out,
    output logic        training,
    output logic [15:0] frame_count
);

    localparam logic [15:0] c_train_last = 16'(TRAIN_LEN - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  w_fsm_word;
    logic [15:0] r_train_cnt;
    logic        r_train_pend;
    logic [15:0] r_frame_count;
    logic        w_enter_train;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge par_clock or posedge reset) begin
        if (reset) begin
            r_state <= TRAIN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and word selection
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_fsm_word   = IDLE_WORD;
        case (r_state)
            TRAIN: begin
                // Requests during a burst are ignored; it never stretches.
                w_fsm_word = TRAIN_WORD;
                if (r_train_cnt == c_train_last) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                if (train_req) begin
                    w_next_state = TRAIN;
                end else if (data_valid) begin
                    w_next_state = SOF;
                end
            end
            SOF: begin
                w_fsm_word   = SOF_WORD;
                w_next_state = DATA;
            end
            DATA: begin
                // Underrun sends IDLE fill but keeps the frame open.
                if (data_valid) begin
                    w_fsm_word = data_in;
                    if (data_last) begin
                        w_next_state = EOF;
                    end
                end
            end
            EOF: begin
                w_fsm_word   = EOF_WORD;
                w_next_state = (train_req || r_train_pend) ? TRAIN : IDLE;
            end
            default: begin
                w_next_state = TRAIN;
            end
        endcase
    end

    assign data_ready    = (r_state == DATA);
    assign training      = (r_state == TRAIN);
    assign w_enter_train = (w_next_state == TRAIN) && (r_state != TRAIN);

    // ------------------------------------------------------------------
    // Training burst length counter
    // ------------------------------------------------------------------
    always_ff @(posedge par_clock or posedge reset) begin
        if (reset) begin
            r_train_cnt <= 16'd0;
        end else if (r_state == TRAIN) begin
            r_train_cnt <= (r_train_cnt == c_train_last) ? 16'd0 : r_train_cnt + 16'd1;
        end else begin
            r_train_cnt <= 16'd0;
        end
    end

    // ------------------------------------------------------------------
    // Deferred training request. Entering TRAIN takes priority so a
    // request in the EOF cycle is consumed rather than left behind.
    // ------------------------------------------------------------------
    always_ff @(posedge par_clock or posedge reset) begin
        if (reset) begin
            r_train_pend <= 1'b0;
        end else if (w_enter_train) begin
            r_train_pend <= 1'b0;
        end else if (train_req && is_frame_state(r_state)) begin
            r_train_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Completed-frame counter, wraps naturally at 16 bits
    // ------------------------------------------------------------------
    always_ff @(posedge par_clock or posedge reset) begin
        if (reset) begin
            r_frame_count <= 16'd0;
        end else if (r_state == EOF) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;

    // ------------------------------------------------------------------
    // Output skew stage
    // ------------------------------------------------------------------
    skew_shift u_skew_shift (
        .par_clock (par_clock),
        .reset     (reset),
        .fsm_word  (w_fsm_word),
        .shift     (shift),
        .data_out  (data_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_multiplex_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplex_framer
//  Description : Self-checking bench for multiplex_framer. Each directed
//                cycle states the word the framer must emit; a compare
//                process derives data_out from that word stream and the
//                skew, and independently recovers the stream with a
//                receiver-style one-hot select window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplex_framer;

    localparam int TLEN = 4;
    localparam int N    = 1024;

    logic        par_clock = 1'b0;
    logic        reset;
    logic        train_req;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_last;
    logic        data_ready;
    logic [2:0]  shift;
    logic [7:0]  data_out;
    logic        training;
    logic [15:0] frame_count;

    multiplex_framer #(
        .TRAIN_LEN (TLEN)
    ) dut (
        .par_clock   (par_clock),
        .reset       (reset),
        .train_req   (train_req),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_last   (data_last),
        .data_ready  (data_ready),
        .shift       (shift),
        .data_out    (data_out),
        .training    (training),
        .frame_count (frame_count)
    );

    always #5 par_clock = ~par_clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ci;
    int model_frames;
    logic chk_en = 1'b0;
    logic [7:0] last_out = 8'h00;

    // Per-cycle expectations, offset by 4 so cycles before reset release
    // read as zero words.
    logic [7:0]  exp_word  [N];
    logic        exp_train [N];
    logic        exp_ready [N];
    logic [15:0] exp_fc    [N];
    logic [2:0]  shift_at  [N];
    logic        lit_v     [N];
    logic [7:0]  lit_val   [N];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Output word for skew s: low byte of {older, newer} shifted right by s.
    function automatic logic [7:0] window(input logic [7:0] cur, input logic [7:0] prev,
                                          input logic [2:0] s);
        logic [15:0] pair;
        pair = {prev, cur};
        pair = pair >> s;
        return pair[7:0];
    endfunction

    // Far-end demultiplexer: select one-hot bit s picks bits [15-s:8-s]
    // from two consecutive received words.
    function automatic logic [7:0] rx_recover(input logic [7:0] first, input logic [7:0] second,
                                              input logic [7:0] sel);
        logic [15:0] pair;
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) if (sel[k]) s = k;
        pair = {first, second};
        pair = pair >> (8 - s);
        return pair[7:0];
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            exp_word[k]  = 8'h00;
            exp_train[k] = 1'b0;
            exp_ready[k] = 1'b0;
            exp_fc[k]    = 16'h0000;
            shift_at[k]  = 3'd0;
            lit_v[k]     = 1'b0;
            lit_val[k]   = 8'h00;
        end
        cyc          = 0;
        model_frames = 0;
    endtask

    task automatic set_lit(input int c, input logic [7:0] v);
        lit_v[c + 4]   = 1'b1;
        lit_val[c + 4] = v;
    endtask

    // One cycle: drive inputs, state what the framer must emit, advance.
    task automatic step(input logic tr, input logic dv, input logic dl, input logic [7:0] din,
                        input logic [7:0] w, input logic et, input logic er);
        int k;
        k = cyc + 4;
        train_req    = tr;
        data_valid   = dv;
        data_last    = dl;
        data_in      = din;
        exp_word[k]  = w;
        exp_train[k] = et;
        exp_ready[k] = er;
        exp_fc[k]    = model_frames[15:0];
        shift_at[k]  = shift;
        @(posedge par_clock);
        #1;
        cyc++;
        if (cyc + 8 >= N) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, N - 8);
            $fatal(1);
        end
    endtask

    task automatic train_burst(input logic tr, input logic dv);
        repeat (TLEN) step(tr, dv, 1'b0, 8'h44, 8'hF0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // Starts in IDLE with data_valid held; gap = underrun cycles between
    // first and second byte; tr_idx = data byte index carrying train_req.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int gap, input int tr_idx);
        step(1'b0, 1'b1, 1'b0, b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, b0, 8'hBC, 1'b0, 1'b0);
        step(tr_idx == 0, 1'b1, 1'b0, b0, b0, 1'b0, 1'b1);
        repeat (gap) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(tr_idx == 1, 1'b1, 1'b0, b1, b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, b2, b2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'hFD, 1'b0, 1'b0);
        model_frames++;
    endtask

    // Compare process
    always @(negedge par_clock) begin
        if (chk_en) begin
            ci = cyc + 4;
            check("training", {15'd0, training}, {15'd0, exp_train[ci]});
            check("data_ready", {15'd0, data_ready}, {15'd0, exp_ready[ci]});
            check("frame_count", frame_count, exp_fc[ci]);
            check("data_out", {8'd0, data_out},
                  {8'd0, window(exp_word[ci-2], exp_word[ci-3], shift_at[ci-1])});
            if (lit_v[ci]) check("data_out_literal", {8'd0, data_out}, {8'd0, lit_val[ci]});
            if (shift_at[ci-1] == shift_at[ci-2])
                check("rx_recover", {8'd0, rx_recover(last_out, data_out, 8'b1 << shift_at[ci-1])},
                      {8'd0, exp_word[ci-3]});
        end
        last_out = data_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1);
    end

    int c;

    initial begin
        reset = 1'b1; train_req = 1'b0; data_in = 8'h00;
        data_valid = 1'b0; data_last = 1'b0; shift = 3'd0;
        clear_model();
        repeat (2) @(posedge par_clock);
        #1;
        check("reset_data_out", {8'd0, data_out}, 16'h0000);
        check("reset_data_ready", {15'd0, data_ready}, 16'h0000);
        check("reset_training", {15'd0, training}, 16'h0001);
        check("reset_frame_count", frame_count, 16'h0000);
        reset = 1'b0;
        chk_en = 1'b1;

        // Training after release, then idle fill
        for (int k = 2; k <= 5; k++) set_lit(k, 8'hF0);
        set_lit(6, 8'h00);
        train_burst(1'b0, 1'b0);
        idle(3);

        // Simple frame
        c = cyc;
        set_lit(c + 3, 8'hBC); set_lit(c + 4, 8'h11); set_lit(c + 5, 8'h22);
        set_lit(c + 6, 8'h33); set_lit(c + 7, 8'hFD); set_lit(c + 8, 8'h00);
        send_frame(8'h11, 8'h22, 8'h33, 0, -1);
        idle(3);
        check("frame_count_after_first", frame_count, 16'd1);

        // Underrun of two cycles
        c = cyc;
        set_lit(c + 3, 8'hBC); set_lit(c + 4, 8'h11); set_lit(c + 5, 8'h00);
        set_lit(c + 6, 8'h00); set_lit(c + 7, 8'h22);
        send_frame(8'h11, 8'h22, 8'h33, 2, -1);
        idle(2);

        // Training request mid-frame: frame closes, then a full burst
        send_frame(8'hA1, 8'hA2, 8'hA3, 0, 0);
        train_burst(1'b1, 1'b0);
        idle(3);

        // Training request beats data_valid in IDLE
        step(1'b1, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0);
        train_burst(1'b0, 1'b1);
        send_frame(8'h44, 8'h55, 8'h66, 0, -1);
        idle(2);

        // Skew of 3 set during training
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        shift = 3'd3;
        train_burst(1'b0, 1'b0);
        idle(2);
        c = cyc;
        set_lit(c + 4, 8'h9F); set_lit(c + 5, 8'hFF); set_lit(c + 6, 8'hE0);
        send_frame(8'hFF, 8'hFF, 8'h00, 0, -1);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        shift = 3'd0;
        train_burst(1'b0, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of a frame
        step(1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h77, 8'hBC, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h77, 8'h77, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h88, 8'h88, 1'b0, 1'b1);
        chk_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_data_out", {8'd0, data_out}, 16'h0000);
        check("async_reset_frame_count", frame_count, 16'h0000);
        check("async_reset_training", {15'd0, training}, 16'h0001);
        check("async_reset_data_ready", {15'd0, data_ready}, 16'h0000);
        data_valid = 1'b0;
        repeat (2) @(posedge par_clock);
        #1;
        reset = 1'b0;
        clear_model();
        set_lit(2, 8'hF0);
        chk_en = 1'b1;
        train_burst(1'b0, 1'b0);
        idle(2);
        send_frame(8'h12, 8'h34, 8'h56, 0, -1);
        idle(3);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
